bcd_entry_rx: RTL and testbench
===============================

Name: bcd_entry_rx

Overview:
- Operator-input front end for the 0..25 up/down counter datapath.
- Accepts a two-digit decimal value keyed in one digit at a time: BCD digit from 4 slide switches, confirmed by a pushbutton.
- Debounces the buttons, validates the digits, and reassembles them into a 5-bit binary value.
- Hands the result to the counter control unit as its preset value, together with a one-cycle start strobe.
- Performs the inverse of the binary-to-BCD display path. Also echoes the entered digits for the 7-segment drivers.

Parameters:
- DEB_CYCLES, 500000, consecutive stable clocks needed to accept a button level change (10 ms at 50 MHz).
- MAX_VAL, 25, largest accepted decimal value.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- digit_sw  input  4  BCD digit from slide switches; sampled on an accepted enter press
- btn_enter  input  1  raw enter pushbutton, active-high, asynchronous to clk
- btn_clear  input  1  raw clear pushbutton, active-high, asynchronous to clk
- n_out  output  5  binary value of the last valid entry
- n_valid  output  1  high while n_out holds a valid entry
- start_pulse  output  1  one-cycle strobe when a valid entry completes
- entry_err  output  1  high after a rejected digit or value; cleared by the next accepted press or by clear
- tens_bcd  output  4  tens digit entered so far (display echo)
- ones_bcd  output  4  ones digit entered so far (display echo)
- await_ones  output  1  high while the FSM waits for the ones digit

Behaviour:
- Reset (async assert, sync release): state GET_TENS; all outputs 0; synchronizer, debounce counters and debounced levels 0.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter (width ceil(log2(DEB_CYCLES+1))). The counter increments while the synchronized level differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A press event is the debounced rising edge: exactly one clk-cycle pulse per physical press, none on release.
  - Latency from a clean raw rising edge to the press pulse is DEB_CYCLES+3 clocks.
- FSM acts on the clock edge where a press pulse is high. digit_sw is sampled on that same edge.
- GET_TENS, on enter:
  - digit_sw <= MAX_VAL/10 (2): tens_bcd <= digit_sw, ones_bcd <= 0, entry_err <= 0, go to GET_ONES.
  - Otherwise: entry_err <= 1, stay in GET_TENS.
- GET_ONES (await_ones = 1), on enter:
  - digit_sw > 9: entry_err <= 1, stay in GET_ONES.
  - Otherwise compute val = tens*10 + ones as (tens<<3)+(tens<<1)+digit_sw, 7 bits wide.
  - val <= MAX_VAL: ones_bcd <= digit_sw, n_out <= val[4:0], n_valid <= 1, start_pulse <= 1 for exactly one cycle, entry_err <= 0, go to GET_TENS.
  - val > MAX_VAL: entry_err <= 1, tens_bcd and ones_bcd <= 0, n_out and n_valid unchanged, go to GET_TENS.
- Clear press, in any state: go to GET_TENS; tens_bcd, ones_bcd, n_out, n_valid, entry_err <= 0. No start_pulse.
- Clear and enter press pulses on the same cycle: clear wins, enter is discarded.
- Previous n_out and n_valid persist while a new entry is in progress. They change only on a valid completion or on clear.
- start_pulse is never high on two consecutive cycles.
- Reset asserted mid-entry: immediate return to reset values; any partial digit is lost.
- Holding a button produces one event only. Bounce shorter than DEB_CYCLES produces no event.

Test Plan (DEB_CYCLES=4 for simulation):
- Reset then idle: all outputs 0, await_ones=0. Raw enter glitch of 3 clocks -> no state change.
- Enter 1 then 7 (clean presses):
  - After the first press: tens_bcd=1, await_ones=1.
  - After the second: n_out=17, n_valid=1, ones_bcd=7, start_pulse high exactly 1 cycle, 7 clocks after the raw edge.
- Enter 2 then 5 -> n_out=25, start_pulse. Then enter 2 then 6 -> entry_err=1, n_out stays 25, tens_bcd=0, no pulse.
- Tens digit 3 -> entry_err=1, stays in GET_TENS. Then tens 0, ones digit 12 -> entry_err=1, await_ones stays 1. Then ones 9 -> n_out=9, entry_err=0.
- After n_out=17: clear and enter pressed on the same cycle -> all outputs 0, no start_pulse.
- Tens 1 entered, rst_n pulsed low mid-entry -> outputs 0 immediately (asynchronously). Then entry 0,0 -> n_out=0, n_valid=1, start_pulse.

Source files
------------

// File: rtl/bcd_entry_rx.sv
// bcd_entry_rx: operator keypad front end for the 0..MAX_VAL counter datapath.
// Two BCD digits are keyed in one at a time (tens first) from the slide
// switches and confirmed with the enter button. A valid entry is reassembled
// into binary and handed over as a preset value with a one-cycle start strobe.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   digit_sw      BCD digit from slide switches, sampled on an accepted enter press
//   btn_enter     raw enter pushbutton (active-high, asynchronous)
//   btn_clear     raw clear pushbutton (active-high, asynchronous)
//   n_out         binary value of the last valid entry
//   n_valid       n_out holds a valid entry
//   start_pulse   one-cycle strobe on a valid completion
//   entry_err     last press was rejected
//   tens_bcd      tens digit echo for the display
//   ones_bcd      ones digit echo for the display
//   await_ones    waiting for the ones digit
module bcd_entry_rx #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned MAX_VAL    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [4:0] n_out,
    output logic       n_valid,
    output logic       start_pulse,
    output logic       entry_err,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic       await_ones
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
    localparam logic [3:0]    MAX_TENS = 4'(MAX_VAL / 10);
    localparam logic [6:0]    MAX_VAL7 = 7'(MAX_VAL);

    localparam logic [0:0] GET_TENS = 1'b0;
    localparam logic [0:0] GET_ONES = 1'b1;

    // Button conditioning; bit 0 is enter, bit 1 is clear.
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    press;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    always_comb begin
        sync1_d = {btn_clear, btn_enter};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            deb_d[i] = deb_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Press fires on the edge where the debounced level rises.
        press = deb_d & ~deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Entry FSM and output registers.
    logic [0:0] state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [4:0] n_q, n_d;
    logic       n_valid_q, n_valid_d;
    logic       start_q, start_d;
    logic       err_q, err_d;
    logic [6:0] val;

    // tens*10 + ones without a multiplier.
    assign val = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, digit_sw};

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        n_d       = n_q;
        n_valid_d = n_valid_q;
        start_d   = 1'b0;
        err_d     = err_q;
        if (press[1]) begin
            // Clear wins over a simultaneous enter.
            state_d   = GET_TENS;
            tens_d    = '0;
            ones_d    = '0;
            n_d       = '0;
            n_valid_d = 1'b0;
            err_d     = 1'b0;
        end else if (press[0]) begin
            if (state_q == GET_TENS) begin
                if (digit_sw <= MAX_TENS) begin
                    tens_d  = digit_sw;
                    ones_d  = '0;
                    err_d   = 1'b0;
                    state_d = GET_ONES;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (digit_sw > 4'd9) begin
                    err_d = 1'b1;
                end else if (val <= MAX_VAL7) begin
                    ones_d    = digit_sw;
                    n_d       = val[4:0];
                    n_valid_d = 1'b1;
                    start_d   = 1'b1;
                    err_d     = 1'b0;
                    state_d   = GET_TENS;
                end else begin
                    err_d   = 1'b1;
                    tens_d  = '0;
                    ones_d  = '0;
                    state_d = GET_TENS;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GET_TENS;
            tens_q    <= '0;
            ones_q    <= '0;
            n_q       <= '0;
            n_valid_q <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            n_q       <= n_d;
            n_valid_q <= n_valid_d;
            start_q   <= start_d;
            err_q     <= err_d;
        end
    end

    assign n_out       = n_q;
    assign n_valid     = n_valid_q;
    assign start_pulse = start_q;
    assign entry_err   = err_q;
    assign tens_bcd    = tens_q;
    assign ones_bcd    = ones_q;
    assign await_ones  = (state_q == GET_ONES);

endmodule

// File: tb/tb_bcd_entry_rx.sv
// Self-checking bench for bcd_entry_rx with a short debounce window.
module tb_bcd_entry_rx;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit_sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [4:0] n_out;
    logic       n_valid;
    logic       start_pulse;
    logic       entry_err;
    logic [3:0] tens_bcd;
    logic [3:0] ones_bcd;
    logic       await_ones;

    int checks = 0;
    int errors = 0;

    bcd_entry_rx #(
        .DEB_CYCLES(DEB),
        .MAX_VAL   (25)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_sw   (digit_sw),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .n_out      (n_out),
        .n_valid    (n_valid),
        .start_pulse(start_pulse),
        .entry_err  (entry_err),
        .tens_bcd   (tens_bcd),
        .ones_bcd   (ones_bcd),
        .await_ones (await_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit cl;
        int dig;
        int n;
        int v;
        int err;
        int tens;
        int ones;
        int aw;
        int st;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: decimal entry rules applied per accepted press.
    int m_n, m_v, m_err, m_tens, m_ones, m_aw, m_st;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int n, input int v, input int err,
                                 input int tens, input int ones, input int aw);
        check({tag, ".n_out"}, int'(n_out), n);
        check({tag, ".n_valid"}, int'(n_valid), v);
        check({tag, ".entry_err"}, int'(entry_err), err);
        check({tag, ".tens_bcd"}, int'(tens_bcd), tens);
        check({tag, ".ones_bcd"}, int'(ones_bcd), ones);
        check({tag, ".await_ones"}, int'(await_ones), aw);
    endtask

    // Clean press and release; counts start strobes and the latency in
    // clocks from the raw edge to the first strobe (-1 if none).
    task automatic press(input bit en, input bit cl, input int d,
                         output int starts, output int lat);
        starts = 0;
        lat    = -1;
        @(negedge clk);
        digit_sw  = 4'(d);
        btn_enter = en;
        btn_clear = cl;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (start_pulse) begin
                starts++;
                if (lat < 0) lat = k;
            end
        end
        @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (start_pulse) starts++;
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_v = 0; m_err = 0; m_tens = 0; m_ones = 0; m_aw = 0; m_st = 0;
    endtask

    task automatic model_apply(input bit en, input bit cl, input int d);
        int value;
        m_st = 0;
        if (cl) begin
            m_n = 0; m_v = 0; m_err = 0; m_tens = 0; m_ones = 0; m_aw = 0;
        end else if (en) begin
            if (m_aw == 0) begin
                if (d <= 2) begin
                    m_tens = d; m_ones = 0; m_err = 0; m_aw = 1;
                end else begin
                    m_err = 1;
                end
            end else if (d > 9) begin
                m_err = 1;
            end else begin
                value = m_tens * 10 + d;
                m_aw  = 0;
                if (value <= 25) begin
                    m_ones = d; m_n = value; m_v = 1; m_err = 0; m_st = 1;
                end else begin
                    m_err = 1; m_tens = 0; m_ones = 0;
                end
            end
        end
    endtask

    initial begin
        int starts, lat, d;
        bit cl;

        vecs[0]  = '{1, 0, 1,  0,  0, 0, 1, 0, 1, 0};
        vecs[1]  = '{1, 0, 7,  17, 1, 0, 1, 7, 0, 1};
        vecs[2]  = '{1, 0, 2,  17, 1, 0, 2, 0, 1, 0};
        vecs[3]  = '{1, 0, 5,  25, 1, 0, 2, 5, 0, 1};
        vecs[4]  = '{1, 0, 2,  25, 1, 0, 2, 0, 1, 0};
        vecs[5]  = '{1, 0, 6,  25, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 3,  25, 1, 1, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 0,  25, 1, 0, 0, 0, 1, 0};
        vecs[8]  = '{1, 0, 12, 25, 1, 1, 0, 0, 1, 0};
        vecs[9]  = '{1, 0, 9,  9,  1, 0, 0, 9, 0, 1};
        vecs[10] = '{1, 0, 1,  9,  1, 0, 1, 0, 1, 0};
        vecs[11] = '{1, 0, 7,  17, 1, 0, 1, 7, 0, 1};
        vecs[12] = '{1, 1, 5,  0,  0, 0, 0, 0, 0, 0};

        digit_sw  = 4'd0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0);
        check("reset.start_pulse", int'(start_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enter glitch shorter than the debounce window.
        @(negedge clk);
        digit_sw  = 4'd1;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        starts = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (start_pulse) starts++;
        end
        check_outputs("glitch", 0, 0, 0, 0, 0, 0);
        check("glitch.starts", starts, 0);

        foreach (vecs[i]) begin
            press(vecs[i].en, vecs[i].cl, vecs[i].dig, starts, lat);
            check_outputs($sformatf("vec%0d", i), vecs[i].n, vecs[i].v, vecs[i].err,
                          vecs[i].tens, vecs[i].ones, vecs[i].aw);
            check($sformatf("vec%0d.starts", i), starts, vecs[i].st);
            if (vecs[i].st != 0) check($sformatf("vec%0d.latency", i), lat, DEB + 3);
        end

        // Asynchronous reset in the middle of an entry.
        press(1, 0, 2, starts, lat);
        press(1, 0, 1, starts, lat);
        check("pre_rst.n_out", int'(n_out), 21);
        press(1, 0, 1, starts, lat);
        check("mid.await_ones", int'(await_ones), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        press(1, 0, 0, starts, lat);
        check("zero_tens.await_ones", int'(await_ones), 1);
        press(1, 0, 0, starts, lat);
        check_outputs("zero", 0, 1, 0, 0, 0, 0);
        check("zero.starts", starts, 1);

        // Randomized presses against the reference model.
        model_reset();
        model_apply(1, 0, 0);
        model_apply(1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cl = ($urandom_range(0, 9) == 0);
            d  = (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9))
                                              : int'($urandom_range(0, 15)));
            press(1, cl, d, starts, lat);
            model_apply(1, cl, d);
            check_outputs($sformatf("rnd%0d", i), m_n, m_v, m_err, m_tens, m_ones, m_aw);
            check($sformatf("rnd%0d.starts", i), starts, m_st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
